// File: rtl/left_shift_sequencer.sv
// -----------------------------------------------------------------------------
// left_shift_sequencer
//
// Multi-cycle left shifter / rotator. The shift is applied as SHW binary-weighted
// stages (2^(SHW-1) first, down to 1), one stage per clock, all on one shared
// work register. Latency is SHW cycles from accept to done, whatever the amount.
//
// Ports
//   clk     in   1      rising-edge clock
//   reset   in   1      asynchronous, active-high; clears all state and outputs
//   start   in   1      request; sampled only while idle
//   a       in   WIDTH  operand, latched on accept
//   shamt   in   SHW    shift amount 0..WIDTH-1, latched on accept
//   rot     in   1      0 = logical left (zero fill), 1 = rotate left
//   busy    out  1      high while a shift is in progress
//   done    out  1      one-cycle pulse, result valid
//   result  out  WIDTH  shifted value, held until the next accept
// -----------------------------------------------------------------------------
module left_shift_sequencer #(
    parameter int WIDTH = 32,
    parameter int SHW   = 5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [SHW-1:0]   shamt,
    input  logic             rot,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result
);

    // Stage index only needs to address the SHW bits of the latched amount.
    localparam int KW = (SHW > 1) ? $clog2(SHW) : 1;
    localparam logic [KW-1:0] K_TOP  = KW'(SHW - 1);
    localparam logic [KW-1:0] K_ZERO = KW'(0);
    localparam logic [KW-1:0] K_ONE  = KW'(1);

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_t;

    state_t             r_state;
    logic [WIDTH-1:0]   r_work;
    logic [SHW-1:0]     r_amt;
    logic               r_rot;
    logic [KW-1:0]      r_k;
    logic [WIDTH-1:0]   r_result;
    logic               r_busy;
    logic               r_done;

    state_t             w_state_nx;
    logic [WIDTH-1:0]   w_work_nx;
    logic [SHW-1:0]     w_amt_nx;
    logic               w_rot_nx;
    logic [KW-1:0]      w_k_nx;
    logic [WIDTH-1:0]   w_result_nx;
    logic               w_busy_nx;
    logic               w_done_nx;
    logic [WIDTH-1:0]   w_stage;

    // One stage: shift by 2^k. Shifting the doubled word {x,x} gives the rotate
    // in the upper half and the zero-filled logical shift in the lower half.
    function automatic logic [WIDTH-1:0] stage_shift(
        input logic [WIDTH-1:0] x,
        input logic [KW-1:0]    k,
        input logic             rot_en
    );
        logic [2*WIDTH-1:0] t;
        t = {x, x} << (32'd1 << k);
        if (rot_en) begin
            stage_shift = t[2*WIDTH-1:WIDTH];
        end else begin
            stage_shift = t[WIDTH-1:0];
        end
    endfunction

    // Work value after the current stage (unchanged when this amount bit is 0).
    always_comb begin
        w_stage = r_work;
        if (r_amt[r_k]) begin
            w_stage = stage_shift(r_work, r_k, r_rot);
        end else begin
            w_stage = r_work;
        end
    end

    // Next-state and next-output logic.
    always_comb begin
        w_state_nx  = r_state;
        w_work_nx   = r_work;
        w_amt_nx    = r_amt;
        w_rot_nx    = r_rot;
        w_k_nx      = r_k;
        w_result_nx = r_result;
        w_busy_nx   = r_busy;
        w_done_nx   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_work_nx  = a;
                    w_amt_nx   = shamt;
                    w_rot_nx   = rot;
                    w_k_nx     = K_TOP;
                    w_busy_nx  = 1'b1;
                    w_state_nx = ST_SHIFT;
                end else begin
                    w_state_nx = ST_IDLE;
                end
            end
            ST_SHIFT: begin
                w_work_nx = w_stage;
                if (r_k == K_ZERO) begin
                    // Final stage: publish directly, result never shows a partial value.
                    w_result_nx = w_stage;
                    w_done_nx   = 1'b1;
                    w_busy_nx   = 1'b0;
                    w_state_nx  = ST_IDLE;
                end else begin
                    w_k_nx = r_k - K_ONE;
                end
            end
            default: begin
                w_state_nx = ST_IDLE;
                w_busy_nx  = 1'b0;
            end
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state  <= ST_IDLE;
            r_work   <= '0;
            r_amt    <= '0;
            r_rot    <= 1'b0;
            r_k      <= K_ZERO;
            r_result <= '0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            r_state  <= w_state_nx;
            r_work   <= w_work_nx;
            r_amt    <= w_amt_nx;
            r_rot    <= w_rot_nx;
            r_k      <= w_k_nx;
            r_result <= w_result_nx;
            r_busy   <= w_busy_nx;
            r_done   <= w_done_nx;
        end
    end

    assign busy   = r_busy;
    assign done   = r_done;
    assign result = r_result;

endmodule

// File: tb/tb_left_shift_sequencer.sv
module tb_left_shift_sequencer;

    logic        clk;
    logic        reset;
    logic        start;
    logic [31:0] a;
    logic [4:0]  shamt;
    logic        rot;
    logic        busy;
    logic        done;
    logic [31:0] result;

    int checks;
    int failures;
    int n_acc;
    int n_done;
    logic [31:0] exp_q[$];

    left_shift_sequencer #(.WIDTH(32), .SHW(5)) dut (
        .clk    (clk),
        .reset  (reset),
        .start  (start),
        .a      (a),
        .shamt  (shamt),
        .rot    (rot),
        .busy   (busy),
        .done   (done),
        .result (result)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] ref_shift(input logic [31:0] x, input logic [4:0] s, input logic r);
        logic [31:0] v;
        if (!r) v = x << s;
        else if (s == 5'd0) v = x;
        else v = (x << s) | (x >> (32 - int'(s)));
        return v;
    endfunction

    // Scoreboard side: every done pulse pops and compares one expected result.
    always @(negedge clk) begin
        if (done === 1'b1) begin
            n_done++;
            chk("busy_in_done", {31'd0, busy}, 32'd0);
            chk("sb_nonempty", {31'd0, exp_q.size() > 0}, 32'd1);
            if (exp_q.size() > 0) chk("result", result, exp_q.pop_front());
        end
    end

    task automatic wait_done(output int n);
        n = 0;
        while (done !== 1'b1 && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
    endtask

    // Drive one request (caller is idle or in a done cycle), push expectation,
    // scramble inputs after accept, and check the latency.
    task automatic do_op(input logic [31:0] xa, input logic [4:0] xs, input logic xr);
        int n;
        start = 1'b1; a = xa; shamt = xs; rot = xr;
        exp_q.push_back(ref_shift(xa, xs, xr));
        n_acc++;
        @(posedge clk); #1;
        start = 1'b0;
        a = $urandom; shamt = 5'($urandom_range(0, 31)); rot = 1'($urandom_range(0, 1));
        chk("busy_after_accept", {31'd0, busy}, 32'd1);
        wait_done(n);
        chk("latency", n, 32'd5);
    endtask

    initial begin
        int n;
        logic [31:0] ra;
        logic [4:0]  rs;
        logic        rr;
        checks = 0; failures = 0; n_acc = 0; n_done = 0;
        reset = 1'b1; start = 1'b0; a = 32'd0; shamt = 5'd0; rot = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_result", result, 32'd0);
        reset = 1'b0;
        @(posedge clk); #1;

        // T1 / T2 / T3 directed
        do_op(32'h0000FFFF, 5'd16, 1'b0);
        do_op(32'hFFFF0000, 5'd16, 1'b1);
        do_op(32'h80000001, 5'd1,  1'b1);
        do_op(32'h00000001, 5'd31, 1'b0);
        do_op(32'h80000000, 5'd1,  1'b0);
        do_op(32'h12345678, 5'd0,  1'b0);
        do_op(32'h12345678, 5'd0,  1'b1);
        @(posedge clk); #1;
        chk("result_hold", result, 32'h12345678);

        // T4: start held high, inputs change every cycle
        start = 1'b1; a = 32'h0000000F; shamt = 5'd4; rot = 1'b0;
        exp_q.push_back(32'h000000F0);
        n_acc++;
        for (int c = 1; c <= 6; c++) begin
            @(posedge clk); #1;
            a = $urandom; shamt = 5'($urandom_range(0, 31)); rot = 1'($urandom_range(0, 1));
            if (c < 6) begin
                chk("t4_busy", {31'd0, busy}, 32'd1);
                chk("t4_nodone", {31'd0, done}, 32'd0);
            end else begin
                chk("t4_done", {31'd0, done}, 32'd1);
                chk("t4_idle", {31'd0, busy}, 32'd0);
                exp_q.push_back(ref_shift(a, shamt, rot));
                n_acc++;
            end
        end
        @(posedge clk); #1;
        start = 1'b0;
        chk("t4_b2b_busy", {31'd0, busy}, 32'd1);
        wait_done(n);
        chk("t4_latency", n, 32'd5);
        @(posedge clk); #1;

        // T5: reset two cycles into an op
        start = 1'b1; a = 32'hFFFFFFFF; shamt = 5'd8; rot = 1'b0;
        exp_q.push_back(32'hFFFFFF00);
        n_acc++;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (2) begin @(posedge clk); #1; end
        reset = 1'b1;
        #1;
        chk("t5_busy", {31'd0, busy}, 32'd0);
        chk("t5_done", {31'd0, done}, 32'd0);
        chk("t5_result", result, 32'd0);
        exp_q.delete();
        n_acc--;
        @(posedge clk); #1;
        reset = 1'b0;
        repeat (6) begin @(posedge clk); #1; end
        chk("t5_result_after", result, 32'd0);
        do_op(32'hFFFFFFFF, 5'd8, 1'b0);

        // T6: random ops
        for (int i = 0; i < 200; i++) begin
            ra = $urandom;
            rs = 5'($urandom_range(0, 31));
            rr = 1'($urandom_range(0, 1));
            do_op(ra, rs, rr);
        end
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("done_count", n_done, n_acc);
        chk("sb_drained", exp_q.size(), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
